// File: rtl/fir_coeff_loader.sv
// Double-buffered FIR coefficient loader: streams order taps into a shadow bank, then swaps banks atomically.
// Latency: last tap accepted at edge N -> bank_sel toggles, coeffs_out updates and load_done pulses at edge N+1 (+1 beat with checksum).
// Backpressure: coeff_ready is high only in LOAD/CHECK; coeff_valid outside those states is ignored.
//
// Ports: clk/reset (async active-low), load_start pulse, coeff_in/coeff_valid/coeff_ready beat handshake,
//        coeffs_out (active bank, tap j at [j*width +: width]), bank_sel, busy, load_done pulse, load_err sticky.
// Optional build macro FIR_COEFF_CHECKSUM_EN adds a trailing checksum beat (sum of taps mod 2^width) before commit.
module fir_coeff_loader #(
  parameter int width = 16,
  parameter int order = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic signed [width-1:0] coeff_in,
  input  logic                    coeff_valid,
  output logic                    coeff_ready,
  output logic [order*width-1:0]  coeffs_out,
  output logic                    bank_sel,
  output logic                    busy,
  output logic                    load_done,
  output logic                    load_err
);

  localparam int CW = $clog2(order) + 1;
  localparam int AW = (order > 1) ? $clog2(order) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
`ifdef FIR_COEFF_CHECKSUM_EN
    CHECK  = 2'd2,
`endif
    COMMIT = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         bank_sel_q, bank_sel_d;
  logic                         load_done_q, load_done_d;
  logic                         load_err_q, load_err_d;
  logic                         shadow_we;
  logic [order-1:0][width-1:0]  bank_q [2];
`ifdef FIR_COEFF_CHECKSUM_EN
  logic [width-1:0]             sum_q, sum_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bank_sel_d  = bank_sel_q;
    load_done_d = 1'b0;
    load_err_d  = load_err_q;
    shadow_we   = 1'b0;
`ifdef FIR_COEFF_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    if (load_start) begin
      // A start always wins, even over a beat on the same edge; restarting
      // mid-load (including in COMMIT) is flagged and the swap never happens.
      state_d    = LOAD;
      cnt_d      = '0;
      load_err_d = (state_q != IDLE);
`ifdef FIR_COEFF_CHECKSUM_EN
      sum_d      = '0;
`endif
    end else begin
      case (state_q)
        LOAD: begin
          if (coeff_valid) begin
            shadow_we = 1'b1;
            cnt_d     = cnt_q + CW'(1);
`ifdef FIR_COEFF_CHECKSUM_EN
            sum_d     = sum_q + coeff_in;
`endif
            if (cnt_q == CW'(order - 1)) begin
`ifdef FIR_COEFF_CHECKSUM_EN
              state_d = CHECK;
`else
              state_d = COMMIT;
`endif
            end
          end
        end
`ifdef FIR_COEFF_CHECKSUM_EN
        CHECK: begin
          if (coeff_valid) begin
            if (coeff_in == sum_q) begin
              state_d = COMMIT;
            end else begin
              load_err_d = 1'b1;
              state_d    = IDLE;
            end
          end
        end
`endif
        COMMIT: begin
          bank_sel_d  = ~bank_sel_q;
          load_done_d = 1'b1;
          state_d     = IDLE;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bank_sel_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      bank_q[0]   <= '0;
      bank_q[1]   <= '0;
`ifdef FIR_COEFF_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bank_sel_q  <= bank_sel_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
`ifdef FIR_COEFF_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
      // Only the shadow bank is ever written; the counter bound keeps the
      // index inside the bank even for non-power-of-two orders.
      if (shadow_we && (cnt_q < CW'(order))) begin
        bank_q[~bank_sel_q][cnt_q[AW-1:0]] <= coeff_in;
      end
    end
  end

`ifdef FIR_COEFF_CHECKSUM_EN
  assign coeff_ready = (state_q == LOAD) || (state_q == CHECK);
`else
  assign coeff_ready = (state_q == LOAD);
`endif
  assign busy       = (state_q != IDLE);
  assign bank_sel   = bank_sel_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign coeffs_out = bank_q[bank_sel_q];

endmodule

// File: tb/tb_fir_coeff_loader.sv
module tb_fir_coeff_loader;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_start;
  logic [15:0]  coeff_in;
  logic         coeff_valid;
  logic         coeff_ready;
  logic [511:0] coeffs_out;
  logic         bank_sel;
  logic         busy;
  logic         load_done;
  logic         load_err;

  int checks = 0;
  int errors = 0;

  fir_coeff_loader #(.width(16), .order(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .coeff_in    (coeff_in),
    .coeff_valid (coeff_valid),
    .coeff_ready (coeff_ready),
    .coeffs_out  (coeffs_out),
    .bank_sel    (bank_sel),
    .busy        (busy),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] taps(input logic [15:0] base, input logic [15:0] step);
    logic [511:0] v;
    v = '0;
    for (int j = 0; j < 32; j++) v[j*16 +: 16] = base + step * 16'(j);
    return v;
  endfunction

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic load_beats(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      coeff_valid = 1'b1;
      coeff_in    = base + 16'(i);
      tick();
    end
    coeff_valid = 1'b0;
  endtask

  // Trailing checksum beat; only present in the checksum build.
  task automatic send_checksum(input logic [15:0] sum);
`ifdef FIR_COEFF_CHECKSUM_EN
    coeff_valid = 1'b1;
    coeff_in    = sum;
    tick();
    coeff_valid = 1'b0;
`else
    coeff_in    = sum;
`endif
  endtask

  initial begin
    reset       = 1'b0;
    load_start  = 1'b0;
    coeff_in    = '0;
    coeff_valid = 1'b0;
    tick();
    tick();
    chk("rst_coeffs", coeffs_out, '0);
    chk("rst_bank_sel", bank_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", coeff_ready, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    reset = 1'b1;
    tick();

    // Stray valid in IDLE is ignored
    coeff_valid = 1'b1;
    coeff_in    = 16'h1234;
    tick();
    coeff_valid = 1'b0;
    chk("idle_valid_busy", busy, 0);
    chk("idle_valid_err", load_err, 0);
    chk("idle_valid_coeffs", coeffs_out, '0);

    // Load 1: taps 1..32 back-to-back
    start_load();
    chk("l1_busy", busy, 1);
    chk("l1_ready", coeff_ready, 1);
    load_beats(32, 16'd1);
    send_checksum(16'd528);
    chk("l1_pre_done", load_done, 0);
    chk("l1_pre_sel", bank_sel, 0);
    chk("l1_pre_coeffs", coeffs_out, '0);
    tick();
    chk("l1_done", load_done, 1);
    chk("l1_sel", bank_sel, 1);
    chk("l1_coeffs", coeffs_out, taps(16'd1, 16'd1));
    chk("l1_idle", busy, 0);
    tick();
    chk("l1_done_pulse", load_done, 0);

    // Load 2: all 0xFFFF with valid on every other cycle
    start_load();
    coeff_in = 16'hFFFF;
    for (int c = 0; c < 63; c++) begin
      coeff_valid = ((c % 2) == 0);
      tick();
      chk("l2_hold_coeffs", coeffs_out, taps(16'd1, 16'd1));
    end
    coeff_valid = 1'b0;
    send_checksum(16'hFFE0);
    chk("l2_hold_sel", bank_sel, 1);
    tick();
    chk("l2_done", load_done, 1);
    chk("l2_sel", bank_sel, 0);
    chk("l2_coeffs", coeffs_out, taps(16'hFFFF, 16'd0));
    tick();

    // Abort after 10 beats, restart coincident with a discarded beat
    start_load();
    load_beats(10, 16'h5555);
    load_start  = 1'b1;
    coeff_valid = 1'b1;
    coeff_in    = 16'hDEAD;
    tick();
    load_start  = 1'b0;
    coeff_valid = 1'b0;
    chk("ab_err", load_err, 1);
    chk("ab_busy", busy, 1);
    chk("ab_sel", bank_sel, 0);
    chk("ab_coeffs", coeffs_out, taps(16'hFFFF, 16'd0));
    load_beats(32, 16'd100);
    send_checksum(16'd3696);
    tick();
    chk("ab_restart_done", load_done, 1);
    chk("ab_restart_sel", bank_sel, 1);
    chk("ab_restart_coeffs", coeffs_out, taps(16'd100, 16'd1));
    chk("ab_err_sticky", load_err, 1);
    tick();
    start_load();
    chk("ab_err_cleared", load_err, 0);
    load_beats(32, 16'd1);
    send_checksum(16'd528);
    tick();
    chk("rl_sel", bank_sel, 0);
    chk("rl_err", load_err, 0);
    chk("rl_coeffs", coeffs_out, taps(16'd1, 16'd1));
    tick();

    // Reset asserted at beat 20 of a load
    start_load();
    load_beats(20, 16'h0700);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_coeffs", coeffs_out, '0);
    chk("mr_sel", bank_sel, 0);
    chk("mr_busy", busy, 0);
    chk("mr_ready", coeff_ready, 0);
    chk("mr_err", load_err, 0);
    tick();
    reset = 1'b1;
    tick();
    start_load();
    load_beats(32, 16'd1);
    send_checksum(16'd528);
    tick();
    chk("mr_reload_done", load_done, 1);
    chk("mr_reload_sel", bank_sel, 1);
    chk("mr_reload_coeffs", coeffs_out, taps(16'd1, 16'd1));
    tick();

`ifdef FIR_COEFF_CHECKSUM_EN
    // Bad checksum: no swap, no done, error set
    start_load();
    load_beats(32, 16'd1);
    send_checksum(16'd527);
    chk("cs_err", load_err, 1);
    chk("cs_busy", busy, 0);
    tick();
    chk("cs_no_done", load_done, 0);
    chk("cs_sel", bank_sel, 1);
    chk("cs_coeffs", coeffs_out, taps(16'd1, 16'd1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
